c64_sampler: RTL and testbench

Read-side audio cartridge for the C64 expansion I/O area: the capture counterpart to the write-only DigiMax DAC block. It takes a 16-bit signed PCM stream from the board audio ADC path and decimates it. Samples are converted to 8-bit offset binary and buffered in a small FIFO, which the 6510 drains by reading $DE00/$DF00. It sits on the same CPU bus tap as the DAC cartridge: addr, data, rd_n and wr_n come from the core bus, and data_out/data_oe go to the core read-data mux.

---
 rtl/c64_sampler.sv | 137 +++++++++++++
 tb/tb_c64_sampler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/c64_sampler.sv
// C64 I/O-area audio capture cartridge: decimates a 16-bit PCM stream into an
// 8-bit offset-binary FIFO that the 6510 drains through $DE00-$DE03/$DF00-$DF03.
module c64_sampler #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [15:0] pcm_in,
    input  logic        pcm_valid
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          en_q, en_d;
    logic [2:0]    dd_q, dd_d;
    logic [2:0]    dec_q, dec_d;
    logic [7:0]    dout_q, dout_d;
    logic          rd_n_q, wr_n_q;
    logic          rd_arm_q, wr_arm_q;

    logic       sel, rd_stb, wr_stb;
    logic [1:0] idx;
    logic       empty, full, take, push, pop, flush, ovf_set, ctl_wr;
    logic [4:0] cnt5;
    logic [7:0] sample8, rd_mux;
    logic       unused;

    assign unused  = ^{data_in[6:4], pcm_in[7:0]};
    assign sel     = (addr[15:8] == 8'hDE || addr[15:8] == 8'hDF)
                     && addr[7:2] == 6'd0;
    assign idx     = addr[1:0];
    assign data_oe = sel && !rd_n;
    assign data_out = dout_q;

    // Arm flags keep a strobe held low across reset from firing after release.
    assign rd_stb = sel && !rd_n && rd_n_q && rd_arm_q;
    assign wr_stb = sel && !wr_n && wr_n_q && wr_arm_q;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign cnt5    = 5'(cnt_q);
    assign sample8 = pcm_in[15:8] ^ 8'h80;

    assign ctl_wr  = wr_stb && idx == 2'd2;
    assign flush   = ctl_wr && data_in[7];
    assign pop     = rd_stb && idx == 2'd0 && !empty;
    assign take    = en_q && pcm_valid && dec_q == 3'd0;
    assign push    = take && (!full || pop);
    assign ovf_set = take && full && !pop;

    always_comb begin
        rd_mux = 8'h00;
        unique case (idx)
            2'd0: rd_mux = empty ? 8'h80 : mem_q[rptr_q];
            2'd1: rd_mux = {empty, full, ovf_q, cnt5};
            2'd2: rd_mux = {4'b0, dd_q, en_q};
            2'd3: rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        dec_d  = dec_q;
        en_d   = en_q;
        dd_d   = dd_q;
        dout_d = dout_q;
        if (rd_stb) dout_d = rd_mux;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop) rptr_d = rptr_q + AW'(1);
        if (push && !pop) cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
        if (rd_stb && idx == 2'd1) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
        if (!en_q) dec_d = 3'd0;
        else if (pcm_valid) dec_d = (dec_q == dd_q) ? 3'd0 : dec_q + 3'd1;
        if (ctl_wr) begin
            en_d = data_in[0];
            dd_d = data_in[3:1];
        end
        if (flush) begin
            cnt_d  = '0;
            wptr_d = '0;
            rptr_d = '0;
            ovf_d  = 1'b0;
            dec_d  = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q] <= sample8;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            ovf_q    <= 1'b0;
            dec_q    <= 3'd0;
            en_q     <= 1'b0;
            dd_q     <= 3'd0;
            dout_q   <= 8'h00;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            rd_arm_q <= 1'b0;
            wr_arm_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            ovf_q    <= ovf_d;
            dec_q    <= dec_d;
            en_q     <= en_d;
            dd_q     <= dd_d;
            dout_q   <= dout_d;
            rd_n_q   <= rd_n;
            wr_n_q   <= wr_n;
            rd_arm_q <= rd_arm_q | rd_n;
            wr_arm_q <= wr_arm_q | wr_n;
        end
    end

endmodule

// File: tb/tb_c64_sampler.sv
// Bench for c64_sampler: queue-based model checked every cycle, directed
// scenarios with literal expectations, then a randomized bus/PCM phase.
module tb_c64_sampler;

    localparam int DEPTH = 16;

    logic        clk, reset, rd_n, wr_n, pcm_valid, data_oe;
    logic [15:0] addr, pcm_in;
    logic [7:0]  data_in, data_out;

    int vectors = 0;
    int miscompares = 0;

    c64_sampler #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rd_n(rd_n), .wr_n(wr_n),
        .addr(addr), .data_in(data_in), .data_out(data_out),
        .data_oe(data_oe), .pcm_in(pcm_in), .pcm_valid(pcm_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    logic [7:0] q[$];
    bit         m_ovf, m_en, m_rdp, m_wrp, m_rda, m_wra;
    int         m_d, m_dec;
    logic [7:0] m_dout;

    function automatic bit decoded(input logic [15:0] a);
        return (a[15:8] == 8'hDE || a[15:8] == 8'hDF) && a[7:2] == 6'd0;
    endfunction

    task automatic check(input string name, input logic [7:0] got,
                         input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rs, ws, take, popping;
        int n, ix;
        logic [7:0] v;
        if (reset) begin
            q.delete();
            m_ovf = 0; m_en = 0; m_d = 0; m_dec = 0;
            m_rdp = 1; m_wrp = 1; m_rda = 0; m_wra = 0;
            m_dout = 8'h00;
            return;
        end
        rs = decoded(addr) && !rd_n && m_rdp && m_rda;
        ws = decoded(addr) && !wr_n && m_wrp && m_wra;
        m_rdp = rd_n; m_rda = m_rda | rd_n;
        m_wrp = wr_n; m_wra = m_wra | wr_n;
        ix = int'(addr[1:0]);
        n = q.size();
        if (rs) begin
            case (ix)
                0: m_dout = (n == 0) ? 8'h80 : q[0];
                1: m_dout = 8'((n == 0) * 128 + (n == DEPTH) * 64
                               + m_ovf * 32 + (n % 32));
                2: m_dout = 8'(m_d * 2 + m_en);
                default: m_dout = 8'h00;
            endcase
        end
        take = m_en && pcm_valid && m_dec == 0;
        popping = rs && ix == 0 && n > 0;
        if (rs && ix == 1) m_ovf = 0;
        if (take && n == DEPTH && !popping) m_ovf = 1;
        if (popping) void'(q.pop_front());
        if (take && (n < DEPTH || popping)) begin
            v = pcm_in[15:8] ^ 8'h80;
            q.push_back(v);
        end
        if (!m_en) m_dec = 0;
        else if (pcm_valid) m_dec = (m_dec == m_d) ? 0 : (m_dec + 1) % 8;
        if (ws && ix == 2) begin
            m_en = data_in[0];
            m_d = int'(data_in[3:1]);
            if (data_in[7]) begin
                q.delete();
                m_ovf = 0;
                m_dec = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check("data_out", data_out, m_dout);
            check("data_oe", {7'd0, data_oe}, {7'd0, !rd_n && decoded(addr)});
        end
    end

    task automatic cpu_rd(input logic [15:0] a, output logic [7:0] v);
        @(posedge clk); #1;
        addr = a; rd_n = 1'b0;
        @(posedge clk); #1;
        v = data_out;
        @(posedge clk); #1;
        rd_n = 1'b1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        addr = a; data_in = d; wr_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr_n = 1'b1;
    endtask

    task automatic pcm(input logic [15:0] s);
        @(posedge clk); #1;
        pcm_in = s; pcm_valid = 1'b1;
        @(posedge clk); #1;
        pcm_valid = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] a,
                          input logic [7:0] exp);
        logic [7:0] v;
        cpu_rd(a, v);
        check(nm, v, exp);
    endtask

    initial begin
        reset = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = 16'h0000;
        data_in = 8'h00; pcm_in = 16'h0000; pcm_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset data_out", data_out, 8'h00);

        rd_chk("status empty", 16'hDE01, 8'h80);
        rd_chk("pop empty", 16'hDE00, 8'h80);
        rd_chk("reg3", 16'hDE03, 8'h00);

        cpu_wr(16'hDE02, 8'h01);
        rd_chk("ctl readback", 16'hDE02, 8'h01);
        pcm(16'h7FFF); pcm(16'h8000); pcm(16'h0000);
        rd_chk("status 3", 16'hDE01, 8'h03);
        rd_chk("pop 7fff", 16'hDE00, 8'hFF);
        rd_chk("pop 8000", 16'hDE00, 8'h00);
        rd_chk("pop 0000", 16'hDE00, 8'h80);
        rd_chk("status drained", 16'hDE01, 8'h80);

        cpu_wr(16'hDE02, 8'h05);
        rd_chk("ctl D2", 16'hDE02, 8'h05);
        for (int i = 0; i < 7; i++) pcm({8'(8'h20 + i), 8'h5A});
        rd_chk("dec status", 16'hDE01, 8'h03);
        rd_chk("dec s0", 16'hDE00, 8'hA0);
        rd_chk("dec s3", 16'hDE00, 8'hA3);
        rd_chk("dec s6", 16'hDE00, 8'hA6);

        cpu_wr(16'hDE02, 8'h80);
        cpu_wr(16'hDE02, 8'h01);
        for (int i = 0; i < 17; i++) pcm({8'(i), 8'h00});
        rd_chk("full ovf", 16'hDE01, 8'h70);
        rd_chk("ovf cleared", 16'hDE01, 8'h50);

        begin
            logic [7:0] v;
            @(posedge clk); #1;
            addr = 16'hDF00; rd_n = 1'b0;
            pcm_in = 16'h4400; pcm_valid = 1'b1;
            @(posedge clk); #1;
            pcm_valid = 1'b0;
            v = data_out;
            @(posedge clk); #1;
            rd_n = 1'b1;
            check("pop+push head", v, 8'h80);
        end
        rd_chk("full no ovf", 16'hDE01, 8'h50);
        for (int i = 1; i < 16; i++) rd_chk("drain", 16'hDE00, 8'(8'h80 + i));
        rd_chk("drain new", 16'hDE00, 8'hC4);
        rd_chk("drained", 16'hDE01, 8'h80);

        cpu_wr(16'hDE02, 8'h81);
        pcm(16'h1100); pcm(16'h2200); pcm(16'h3300);
        @(posedge clk); #1;
        addr = 16'hDE00; rd_n = 1'b0;
        repeat (20) @(posedge clk);
        #1 rd_n = 1'b1;
        rd_chk("long read", 16'hDE01, 8'h02);
        @(posedge clk); #1;
        addr = 16'hDE02; data_in = 8'h81; wr_n = 1'b0;
        pcm_in = 16'h5500; pcm_valid = 1'b1;
        @(posedge clk); #1;
        pcm_valid = 1'b0;
        @(posedge clk); #1;
        wr_n = 1'b1;
        rd_chk("flush wins", 16'hDE01, 8'h80);

        for (int c = 0; c < 4000; c++) begin
            logic [7:0] pg;
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0) rd_n = ~rd_n;
            if ($urandom_range(0, 9) == 0) wr_n = ~wr_n;
            case ($urandom_range(0, 2))
                0: pg = 8'hDE;
                1: pg = 8'hDF;
                default: pg = 8'hDD;
            endcase
            if ($urandom_range(0, 2) != 0)
                addr = {pg, 6'd0, 2'($urandom)};
            else
                addr = {pg, 8'($urandom)};
            data_in = 8'($urandom);
            data_in[7] = ($urandom_range(0, 15) == 0);
            pcm_in = 16'($urandom);
            pcm_valid = ($urandom_range(0, 1) == 0);
        end

        @(posedge clk); #1;
        rd_n = 1'b1; wr_n = 1'b1; pcm_valid = 1'b0;
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
